// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: word size, reset PC
// and the fetch FSM state encoding.
package imem_fetch_ctrl_pkg;

  localparam int          DEFAULT_WORD_SIZE = 32;
  localparam logic [63:0] DEFAULT_RESET_PC  = 64'd0;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch controller bus: instruction memory port, decode handshake and the
// redirect/halt controls coming back from the pipeline.
interface imem_fetch_ctrl_if
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);

  logic [WORD_SIZE-1:0] imem_addr;
  logic [31:0]          imem_data;
  logic                 ins_valid;
  logic                 ins_ready;
  logic [31:0]          ins_word;
  logic [WORD_SIZE-1:0] ins_pc;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 halt;

  modport master (
    output imem_addr,
    input  imem_data,
    output ins_valid,
    input  ins_ready,
    output ins_word,
    output ins_pc,
    input  redirect,
    input  redirect_pc,
    input  halt
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  ins_valid,
    output ins_ready,
    input  ins_word,
    input  ins_pc,
    output redirect,
    output redirect_pc,
    output halt
  );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Small circular instruction queue with push/pop/flush. The head is read out of
// storage registers; an empty queue presents zero on rdata.
module fetch_queue
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage is deliberately unreset; pointers and count define what is live
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: boot/fetch/halt sequencing, fetch PC with
// redirect, and a decoupling queue towards decode.
//
// state  | meaning
// BOOT   | first cycle after reset, no fetch
// FETCH  | pushing one instruction per cycle while queue has room
// HALTED | no new fetches, queue drains, redirects still accepted
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int                   WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int                   QDEPTH    = 2,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(DEFAULT_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_fetch_ctrl_if.master    bus,
  output logic [1:0]           fsm_state
);

  localparam int QW = 32 + WORD_SIZE;
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t         state_q;
  fetch_state_t         state_d;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic                 flush;
  logic                 pop_fire;
  logic                 push_en;
  logic                 q_full;
  logic                 q_empty;
  logic [CW-1:0]        q_count;
  logic [QW-1:0]        q_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    flush    = 1'b0;
    pop_fire = 1'b0;
    push_en  = 1'b0;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (bus.halt) state_d = HALTED;
      HALTED:  if (!bus.halt) state_d = FETCH;
      default: state_d = BOOT;
    endcase
    // redirect wins over both push and pop; in BOOT it is dropped entirely
    flush    = bus.redirect && (state_q != BOOT);
    pop_fire = bus.ins_ready && !q_empty && !flush;
    push_en  = (state_q == FETCH) && !bus.halt && !bus.redirect &&
               (!q_full || pop_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fetch_pc <= RESET_PC;
    else if (flush)   fetch_pc <= bus.redirect_pc;
    else if (push_en) fetch_pc <= fetch_pc + WORD_SIZE'(1);
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_en),
    .pop   (pop_fire),
    .flush (flush),
    .wdata ({bus.imem_data, fetch_pc}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign bus.imem_addr             = fetch_pc;
  assign bus.ins_valid             = (q_count != '0);
  assign {bus.ins_word, bus.ins_pc} = q_rdata;
  assign fsm_state                 = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a cycle table covering stream, stall,
// redirect, halt and PC wrap, followed by async reset and BOOT-redirect checks.
module tb_imem_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] fsm_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  imem_fetch_ctrl_if #(.WORD_SIZE(32)) bus();

  // memory model: word[i] = i + 0x100
  assign bus.imem_data = bus.imem_addr + 32'h100;

  imem_fetch_ctrl #(
    .WORD_SIZE (32),
    .QDEPTH    (2),
    .RESET_PC  (32'd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        halt;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_word;
    logic [31:0] exp_addr;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic h, input logic r, input logic [31:0] rpc,
                     input logic rdy, input logic ev, input logic [31:0] epc,
                     input logic [31:0] ew, input logic [31:0] ea,
                     input logic [1:0] es);
    vec_t v;
    v.halt = h; v.redirect = r; v.rpc = rpc; v.ready = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_word = ew;
    v.exp_addr = ea; v.exp_state = es;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // columns: halt redir rpc ready | valid pc word addr state
    add(0, 0, 0,            0, 0, 0,            0,        32'h0,        2'd0);
    add(0, 0, 0,            0, 0, 0,            0,        32'h0,        2'd1);
    add(0, 0, 0,            0, 1, 32'h0,        32'h100,  32'h1,        2'd1);
    add(0, 0, 0,            0, 1, 32'h0,        32'h100,  32'h2,        2'd1);
    add(0, 0, 0,            0, 1, 32'h0,        32'h100,  32'h2,        2'd1);
    add(0, 0, 0,            0, 1, 32'h0,        32'h100,  32'h2,        2'd1);
    add(0, 0, 0,            1, 1, 32'h0,        32'h100,  32'h2,        2'd1);
    add(0, 0, 0,            1, 1, 32'h1,        32'h101,  32'h3,        2'd1);
    add(0, 1, 32'h40,       1, 1, 32'h2,        32'h102,  32'h4,        2'd1);
    add(0, 0, 0,            1, 0, 0,            0,        32'h40,       2'd1);
    add(0, 0, 0,            1, 1, 32'h40,       32'h140,  32'h41,       2'd1);
    add(0, 0, 0,            0, 1, 32'h41,       32'h141,  32'h42,       2'd1);
    add(1, 0, 0,            0, 1, 32'h41,       32'h141,  32'h43,       2'd1);
    add(1, 0, 0,            1, 1, 32'h41,       32'h141,  32'h43,       2'd2);
    add(1, 0, 0,            1, 1, 32'h42,       32'h142,  32'h43,       2'd2);
    add(1, 1, 32'h10,       1, 0, 0,            0,        32'h43,       2'd2);
    add(0, 0, 0,            1, 0, 0,            0,        32'h10,       2'd2);
    add(0, 0, 0,            1, 0, 0,            0,        32'h10,       2'd1);
    add(0, 1, 32'hFFFFFFFF, 1, 1, 32'h10,       32'h110,  32'h11,       2'd1);
    add(0, 0, 0,            1, 0, 0,            0,        32'hFFFFFFFF, 2'd1);
    add(0, 0, 0,            1, 1, 32'hFFFFFFFF, 32'hFF,   32'h0,        2'd1);
    add(0, 0, 0,            1, 1, 32'h0,        32'h100,  32'h1,        2'd1);
    add(0, 0, 0,            1, 1, 32'h1,        32'h101,  32'h2,        2'd1);

    rst_n = 1'b0;
    bus.halt = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.ins_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset valid", {31'd0, bus.ins_valid}, 32'd0);
    check("reset addr",  bus.imem_addr, 32'd0);
    check("reset state", {30'd0, fsm_state}, 32'd0);
    check("reset pc",    bus.ins_pc, 32'd0);
    check("reset word",  bus.ins_word, 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      bus.halt        = vq[i].halt;
      bus.redirect    = vq[i].redirect;
      bus.redirect_pc = vq[i].rpc;
      bus.ins_ready   = vq[i].ready;
      #1;
      check($sformatf("v%0d state", i), {30'd0, fsm_state}, {30'd0, vq[i].exp_state});
      check($sformatf("v%0d addr", i),  bus.imem_addr, vq[i].exp_addr);
      check($sformatf("v%0d valid", i), {31'd0, bus.ins_valid}, {31'd0, vq[i].exp_valid});
      if (vq[i].exp_valid) begin
        check($sformatf("v%0d ins_pc", i),   bus.ins_pc, vq[i].exp_pc);
        check($sformatf("v%0d ins_word", i), bus.ins_word, vq[i].exp_word);
      end
      @(negedge clk);
    end

    // async reset mid-stream with a non-empty queue, away from any clock edge
    bus.halt = 1'b0; bus.redirect = 1'b0; bus.ins_ready = 1'b0;
    #2;
    check("pre-reset valid", {31'd0, bus.ins_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset valid", {31'd0, bus.ins_valid}, 32'd0);
    check("async reset addr",  bus.imem_addr, 32'd0);
    check("async reset state", {30'd0, fsm_state}, 32'd0);
    check("async reset pc",    bus.ins_pc, 32'd0);
    @(negedge clk);
    check("held reset valid", {31'd0, bus.ins_valid}, 32'd0);

    // redirect during BOOT must be ignored
    rst_n = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h77; bus.ins_ready = 1'b1;
    #1;
    check("boot state", {30'd0, fsm_state}, 32'd0);
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    check("boot redirect state", {30'd0, fsm_state}, 32'd1);
    check("boot redirect addr",  bus.imem_addr, 32'd0);
    check("boot redirect valid", {31'd0, bus.ins_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("post boot valid", {31'd0, bus.ins_valid}, 32'd1);
    check("post boot pc",    bus.ins_pc, 32'd0);
    check("post boot word",  bus.ins_word, 32'h100);
    check("post boot addr",  bus.imem_addr, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
